// File: rtl/store_pkg.sv
// Shared definitions for the execute-stage store unit: opcodes, FSM states, byte enables.
package store_pkg;

   localparam logic [5:0] OP_SB = 6'h28;
   localparam logic [5:0] OP_SH = 6'h29;
   localparam logic [5:0] OP_SW = 6'h2B;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam logic [3:0] BE_NONE    = 4'h0;
   localparam logic [3:0] BE_WORD    = 4'hF;
   localparam logic [3:0] BE_HALF_LO = 4'h3;
   localparam logic [3:0] BE_HALF_HI = 4'hC;
   localparam logic [3:0] BE_BYTE0   = 4'h1;

   function automatic logic is_store(input logic [5:0] opcode);
      return (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
   endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: replicates store data onto byte lanes and flags
// misaligned or unsupported stores. No state, no handshake.
import store_pkg::*;

module store_lane_align (
   input  logic [5:0]  opcode,
   input  logic [1:0]  ea_lo,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned,
   output logic        unsupported
);

   always_comb begin
      wdata       = data;
      be          = BE_WORD;
      misaligned  = 1'b0;
      unsupported = !is_store(opcode);
      case (opcode)
         OP_SW: begin
            misaligned = (ea_lo != 2'b00);
         end
         OP_SH: begin
            wdata      = {2{data[15:0]}};
            be         = ea_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            misaligned = ea_lo[0];
         end
         OP_SB: begin
            wdata = {4{data[7:0]}};
            be    = BE_BYTE0 << ea_lo;
         end
         default: begin
            be = BE_NONE;
         end
      endcase
   end

endmodule

// File: rtl/store_operation.sv
// Execute-stage store unit: EA = base + sext(imm16), lane alignment, and a single
// memory write with ready handshake and timeout; reports done/error pulses.
import store_pkg::*;

module store_operation #(
   parameter int ADDR_W   = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       instruction,
   input  logic [31:0]       base_value,
   input  logic [31:0]       store_data,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              mem_we,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t           state;
   logic [5:0]       op_q;
   logic [31:0]      ea_q;
   logic [31:0]      data_q;
   logic [CNT_W-1:0] wait_cnt;

   logic [31:0] ea_next;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic        lane_misaligned;
   logic        lane_unsupported;
   logic        unused_instr_bits;

   // Carry out of bit 31 is dropped: EA wraps modulo 2^32.
   assign ea_next = base_value + {{16{instruction[15]}}, instruction[15:0]};
   assign unused_instr_bits = ^instruction[25:16];

   store_lane_align u_align (
      .opcode      (op_q),
      .ea_lo       (ea_q[1:0]),
      .data        (data_q),
      .wdata       (lane_wdata),
      .be          (lane_be),
      .misaligned  (lane_misaligned),
      .unsupported (lane_unsupported)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= '0;
         ea_q      <= '0;
         data_q    <= '0;
         wait_cnt  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         mem_we    <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= instruction[31:26];
                  ea_q   <= ea_next;
                  data_q <= store_data;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               wait_cnt <= '0;
               if (lane_unsupported || lane_misaligned) begin
                  error <= 1'b1;
                  state <= ERR;
               end else begin
                  mem_addr  <= ea_q[ADDR_W-1:0];
                  mem_wdata <= lane_wdata;
                  mem_be    <= lane_be;
                  mem_we    <= 1'b1;
                  state     <= WRITE;
               end
            end
            WRITE: begin
               // Ready is tested before the timeout so a late accept still succeeds.
               if (mem_ready) begin
                  mem_we <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  mem_we <= 1'b0;
                  error  <= 1'b1;
                  state  <= ERR;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_store_operation.sv
// Directed plus randomized bench for store_operation; expectations come from a
// byte-level reference model of the store rules.
module tb_store_operation;

   localparam int WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] base_value = '0;
   logic [31:0] store_data = '0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_err = 0;

   store_operation #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .instruction (instruction),
      .base_value  (base_value),
      .store_data  (store_data),
      .mem_ready   (mem_ready),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_we      (mem_we),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: a store of SIZE bytes at byte address EA; lane i carries data byte (i mod SIZE).
   function automatic void model(input logic [31:0] instr, input logic [31:0] base,
                                 input logic [31:0] data, output bit ok,
                                 output logic [31:0] ea, output logic [31:0] wd,
                                 output logic [3:0] be);
      int size;
      int off;
      int lo;
      off = $signed(instr[15:0]);
      ea  = base + off;
      case (instr[31:26])
         6'h28:   size = 1;
         6'h29:   size = 2;
         6'h2B:   size = 4;
         default: size = 0;
      endcase
      ok = (size != 0) && ((ea % size) == 0);
      lo = int'(ea % 4);
      wd = '0;
      be = '0;
      for (int i = 0; i < 4; i++) begin
         if (size != 0) wd[8*i +: 8] = data[8*(i % size) +: 8];
         be[i] = (i >= lo) && (i < lo + size);
      end
   endfunction

   // delay: wait cycles before ready (negative = never); junk: toggle start/ready when they must be ignored.
   task automatic run_store(input logic [31:0] instr, input logic [31:0] base,
                            input logic [31:0] data, input int delay, input bit junk);
      bit          ok;
      bit          fin;
      bit          rdy;
      int          w;
      logic [31:0] ea;
      logic [31:0] wd;
      logic [3:0]  be;
      model(instr, base, data, ok, ea, wd, be);
      @(negedge clk);
      instruction = instr;
      base_value  = base;
      store_data  = data;
      start       = 1'b1;
      @(negedge clk);
      start       = junk;
      mem_ready   = junk;
      instruction = $urandom;
      base_value  = $urandom;
      store_data  = $urandom;
      chk("check_busy", busy, 1);
      chk("check_we", mem_we, 0);
      chk("check_no_done", done, 0);
      @(negedge clk);
      mem_ready = 1'b0;
      if (!ok) begin
         start = 1'b0;
         chk("err_pulse", error, 1);
         chk("err_we", mem_we, 0);
         chk("err_no_done", done, 0);
         @(negedge clk);
         chk("err_clear", error, 0);
         chk("err_idle", busy, 0);
         chk("err_we_after", mem_we, 0);
         return;
      end
      w   = 0;
      fin = 1'b0;
      while (!fin) begin
         chk("write_we", mem_we, 1);
         chk("write_addr", mem_addr, ea);
         chk("write_wdata", mem_wdata, wd);
         chk("write_be", {28'b0, mem_be}, {28'b0, be});
         chk("write_no_pulse", {done, error}, 0);
         rdy       = (delay >= 0) && (w == delay);
         mem_ready = rdy;
         start     = junk;
         @(negedge clk);
         mem_ready = 1'b0;
         w++;
         if (rdy) begin
            chk("done_pulse", done, 1);
            chk("done_we", mem_we, 0);
            chk("done_no_err", error, 0);
            fin = 1'b1;
         end else if (w >= WAIT_MAX) begin
            chk("timeout_err", error, 1);
            chk("timeout_we", mem_we, 0);
            chk("timeout_no_done", done, 0);
            chk("timeout_we_cycles", w, WAIT_MAX);
            fin = 1'b1;
         end
      end
      start = 1'b0;
      @(negedge clk);
      chk("end_pulses", {done, error}, 0);
      chk("end_idle", busy, 0);
      chk("hold_addr", mem_addr, ea);
      chk("hold_wdata", mem_wdata, wd);
   endtask

   initial begin
      logic [5:0]  ops[5];
      logic [31:0] instr;
      ops[0] = 6'h28; ops[1] = 6'h29; ops[2] = 6'h2B; ops[3] = 6'h2B; ops[4] = 6'h23;

      // Reset state
      @(negedge clk);
      chk("rst_outputs", {mem_we, busy, done, error}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_be", {28'b0, mem_be}, 0);
      @(negedge clk);
      reset = 1'b1;

      // Word, byte and half-word lanes
      run_store(32'hAC090004, 32'h00001000, 32'h12345678, 0, 1'b0);
      chk("t1_addr_const", mem_addr, 32'h00001004);
      run_store(32'hA0090003, 32'h00001000, 32'h000000AB, 0, 1'b0);
      chk("t2_sb_wdata_const", mem_wdata, 32'hABABABAB);
      chk("t2_sb_be_const", {28'b0, mem_be}, 32'h8);
      run_store(32'hA4090002, 32'h00001000, 32'h0000BEEF, 0, 1'b0);
      chk("t2_sh_wdata_const", mem_wdata, 32'hBEEFBEEF);
      chk("t2_sh_be_const", {28'b0, mem_be}, 32'hC);

      // Negative offset, misaligned half, unsupported opcode
      run_store(32'hAC09FFFC, 32'h00001000, 32'hCAFEF00D, 1, 1'b0);
      chk("t3_negoff_addr", mem_addr, 32'h00000FFC);
      run_store(32'hA4090001, 32'h00001000, 32'h00001111, 0, 1'b0);
      run_store(32'h8C090000, 32'h00001000, 32'h00002222, 0, 1'b0);

      // Timeout, then late ready
      run_store(32'hAC090010, 32'h00002000, 32'h55AA55AA, -1, 1'b0);
      run_store(32'hAC090020, 32'h00002000, 32'hA5A5A5A5, 3, 1'b0);
      run_store(32'hAC090030, 32'h00002000, 32'h0F0F0F0F, WAIT_MAX - 1, 1'b0);

      // Reset while the write strobe is up
      @(negedge clk);
      instruction = 32'hAC090008;
      base_value  = 32'h00003000;
      store_data  = 32'hDEADBEEF;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rst_mid_we_before", mem_we, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_mid_outputs", {mem_we, busy, done, error}, 0);
      chk("rst_mid_addr", mem_addr, 0);
      @(negedge clk);
      chk("rst_mid_no_pulse", {done, error}, 0);
      reset = 1'b1;
      run_store(32'hAC090008, 32'h00003000, 32'hDEADBEEF, 0, 1'b0);

      // Start/ready noise while busy, then back-to-back requests
      run_store(32'hA4090006, 32'h00004000, 32'h00007777, 2, 1'b1);
      run_store(32'hA0090005, 32'h00004000, 32'h00000042, 0, 1'b0);

      // Randomized stores
      for (int k = 0; k < 40; k++) begin
         instr = {ops[$urandom_range(0, 4)], 10'($urandom), 16'($urandom)};
         run_store(instr, $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)),
                   1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
